// File: rtl/drbg_keystream_buffer.sv
`timescale 1ns/1ps
// Buffers 256-bit DRBG words in a small FIFO and serializes them LSB-first
// into narrow key slices with a valid/ready handshake.
module drbg_keystream_buffer #(
    parameter int DATA_WIDTH = 256,
    parameter int OUT_WIDTH  = 8,
    parameter int DEPTH      = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        drbg_init_ready,
    output logic                        next_bits,
    input  logic                        next_bits_ready,
    input  logic [DATA_WIDTH-1:0]       random_bits,
    input  logic                        flush,
    output logic                        key_valid,
    input  logic                        key_ready,
    output logic [OUT_WIDTH-1:0]        key_data,
    output logic [$clog2(DEPTH):0]      words_level,
    output logic                        underrun
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int SLICES = DATA_WIDTH / OUT_WIDTH;
    localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [IDX_W-1:0]        slice_idx;
    logic                    capture;
    logic                    wr_en;
    logic                    consume;
    logic                    last_slice;
    logic [DATA_WIDTH-1:0]   head_word;

    // A flush in the capture cycle discards the word, but the FSM still sees the handshake.
    assign capture    = (state == REQ) && next_bits_ready;
    assign wr_en      = capture && !flush;
    assign key_valid  = (words_level != '0);
    assign consume    = key_valid && key_ready;
    assign last_slice = consume && (slice_idx == LAST_IDX);
    assign head_word  = mem[rd_ptr];
    assign key_data   = key_valid ? head_word[int'(slice_idx)*OUT_WIDTH +: OUT_WIDTH] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            next_bits <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (drbg_init_ready && (words_level < FULL_LVL)) begin
                        state     <= REQ;
                        next_bits <= 1'b1;
                    end
                end
                REQ: begin
                    if (next_bits_ready) begin
                        state     <= DRAIN;
                        next_bits <= 1'b0;
                    end
                end
                // Wait for the DRBG to drop its ready level so one word is never taken twice.
                DRAIN: begin
                    if (!next_bits_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    next_bits <= 1'b0;
                end
            endcase
        end
    end

    // Word storage carries no reset; validity is tracked by words_level alone.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= random_bits;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            slice_idx   <= '0;
            words_level <= '0;
            underrun    <= 1'b0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            slice_idx   <= '0;
            words_level <= '0;
            underrun    <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (last_slice) begin
                slice_idx <= '0;
                rd_ptr    <= rd_ptr + 1'b1;
            end else if (consume) begin
                slice_idx <= slice_idx + 1'b1;
            end
            case ({wr_en, last_slice})
                2'b10:   words_level <= words_level + 1'b1;
                2'b01:   words_level <= words_level - 1'b1;
                default: words_level <= words_level;
            endcase
            if (key_ready && !key_valid) begin
                underrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_drbg_keystream_buffer.sv
`timescale 1ns/1ps
// Directed self-checking bench for drbg_keystream_buffer at default parameters.
module tb_drbg_keystream_buffer;

    logic         clk = 1'b0;
    logic         reset;
    logic         drbg_init_ready;
    logic         next_bits;
    logic         next_bits_ready;
    logic [255:0] random_bits;
    logic         flush;
    logic         key_valid;
    logic         key_ready;
    logic [7:0]   key_data;
    logic [1:0]   words_level;
    logic         underrun;

    int errors = 0;
    int checks = 0;

    drbg_keystream_buffer dut (
        .clk             (clk),
        .reset           (reset),
        .drbg_init_ready (drbg_init_ready),
        .next_bits       (next_bits),
        .next_bits_ready (next_bits_ready),
        .random_bits     (random_bits),
        .flush           (flush),
        .key_valid       (key_valid),
        .key_ready       (key_ready),
        .key_data        (key_data),
        .words_level     (words_level),
        .underrun        (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Word whose byte i equals base+i (mod 256).
    function automatic logic [255:0] mk(input logic [7:0] base);
        logic [255:0] w;
        for (int i = 0; i < 32; i++) w[i*8 +: 8] = base + 8'(i);
        return w;
    endfunction

    task automatic wait_req(input string tag, input int max_cycles);
        int n = 0;
        while (!next_bits && n < max_cycles) begin
            tick();
            n++;
        end
        check(tag, next_bits, 1'b1);
    endtask

    task automatic deliver(input string tag, input logic [255:0] w, input int hold, input int max_wait);
        wait_req(tag, max_wait);
        next_bits_ready = 1'b1;
        random_bits     = w;
        repeat (hold) tick();
        next_bits_ready = 1'b0;
    endtask

    task automatic consume(input string tag, input logic [7:0] base, input int count);
        logic [7:0] e;
        key_ready = 1'b1;
        for (int k = 0; k < count; k++) begin
            e = base + 8'(k);
            check({tag, "_valid"}, key_valid, 1'b1);
            check({tag, "_data"}, key_data, e);
            tick();
        end
        key_ready = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        drbg_init_ready = 1'b0;
        next_bits_ready = 1'b0;
        random_bits     = '0;
        flush           = 1'b0;
        key_ready       = 1'b0;
        tick();
        tick();
        check("rst_next_bits", next_bits, 1'b0);
        check("rst_key_valid", key_valid, 1'b0);
        check("rst_key_data", key_data, 8'h00);
        check("rst_level", words_level, 2'd0);
        check("rst_underrun", underrun, 1'b0);

        // First word: request within 2 cycles, then 32 slices 0x01..0x20.
        reset           = 1'b0;
        drbg_init_ready = 1'b1;
        deliver("first_req", mk(8'h01), 1, 2);
        drbg_init_ready = 1'b0;
        check("cap_next_bits", next_bits, 1'b0);
        check("cap_level", words_level, 2'd1);
        check("cap_valid", key_valid, 1'b1);
        check("cap_data", key_data, 8'h01);
        consume("w0", 8'h01, 32);
        check("w0_empty_valid", key_valid, 1'b0);
        check("w0_empty_level", words_level, 2'd0);
        check("w0_no_underrun", underrun, 1'b0);
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        check("underrun_set", underrun, 1'b1);
        check("empty_data", key_data, 8'h00);

        // Fill with key_ready low; a 5-cycle ready level captures only one word.
        drbg_init_ready = 1'b1;
        deliver("fill1_req", mk(8'h40), 5, 4);
        check("hold5_level", words_level, 2'd1);
        check("hold5_next_bits", next_bits, 1'b0);
        deliver("fill2_req", mk(8'h80), 1, 4);
        check("full_level", words_level, 2'd2);
        repeat (4) tick();
        check("full_no_req", next_bits, 1'b0);
        check("full_level_hold", words_level, 2'd2);
        check("underrun_sticky", underrun, 1'b1);

        // Flush after 5 slices with two words buffered.
        consume("w1", 8'h40, 5);
        check("pre_flush_data", key_data, 8'h45);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_level", words_level, 2'd0);
        check("flush_valid", key_valid, 1'b0);
        check("flush_underrun", underrun, 1'b0);
        deliver("post_flush_req", mk(8'hC0), 1, 4);
        check("post_flush_slice0", key_data, 8'hC0);
        check("post_flush_level", words_level, 2'd1);
        consume("w3", 8'hC0, 1);
        check("w3_slice1", key_data, 8'hC1);

        // Flush coincident with capture drops the word; FSM re-requests via DRAIN/IDLE.
        wait_req("drop_req", 4);
        next_bits_ready = 1'b1;
        random_bits     = mk(8'hEE);
        flush           = 1'b1;
        tick();
        next_bits_ready = 1'b0;
        flush           = 1'b0;
        check("drop_level", words_level, 2'd0);
        check("drop_valid", key_valid, 1'b0);
        check("drop_next_bits", next_bits, 1'b0);
        deliver("rereq", mk(8'h11), 1, 4);
        check("rereq_data", key_data, 8'h11);
        check("rereq_level", words_level, 2'd1);

        // Asynchronous reset while serializing and with a request outstanding.
        key_ready = 1'b1;
        repeat (3) tick();
        key_ready = 1'b0;
        check("mid_next_bits", next_bits, 1'b1);
        check("mid_data", key_data, 8'h14);
        #2;
        reset = 1'b1;
        #1;
        check("async_next_bits", next_bits, 1'b0);
        check("async_valid", key_valid, 1'b0);
        check("async_level", words_level, 2'd0);
        check("async_data", key_data, 8'h00);
        drbg_init_ready = 1'b0;
        #2;
        reset = 1'b0;
        tick();
        tick();
        check("restart_idle", next_bits, 1'b0);

        // Streaming: DRBG answers 10 cycles after each request, consumer always ready.
        drbg_init_ready = 1'b1;
        fork
            begin
                for (int w = 0; w < 2; w++) begin
                    wait_req("stream_req", 10);
                    repeat (10) tick();
                    next_bits_ready = 1'b1;
                    random_bits     = (w == 0) ? mk(8'h21) : mk(8'h61);
                    tick();
                    next_bits_ready = 1'b0;
                end
            end
            begin
                int n;
                logic [7:0] e;
                n = 0;
                while (!key_valid && n < 40) begin
                    tick();
                    n++;
                end
                check("stream_first_valid", key_valid, 1'b1);
                key_ready = 1'b1;
                for (int i = 0; i < 64; i++) begin
                    e = (i < 32) ? 8'h21 + 8'(i) : 8'h61 + 8'(i - 32);
                    check("stream_valid", key_valid, 1'b1);
                    check("stream_data", key_data, e);
                    tick();
                end
                check("stream_underrun", underrun, 1'b0);
                check("stream_drained", words_level, 2'd0);
                tick();
                key_ready = 1'b0;
                check("stream_underrun_late", underrun, 1'b1);
            end
        join

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
